// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase controller, its rotor emulator
// and the bench: phase index type, coil-drive vectors and move classes.
package stepper_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [5:0] drive_t;  // {A,B,C,D,INH1,INH2}

  localparam drive_t P0 = 6'b010111;
  localparam drive_t P1 = 6'b001101;
  localparam drive_t P2 = 6'b100111;
  localparam drive_t P3 = 6'b100010;
  localparam drive_t P4 = 6'b101011;
  localparam drive_t P5 = 6'b001001;
  localparam drive_t P6 = 6'b011011;
  localparam drive_t P7 = 6'b010010;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    JUMP = 3'd5
  } move_t;

  // Classify a forward phase distance (new - ref, mod 8) into a move.
  function automatic move_t classify(input phase_t delta);
    move_t m;
    case (delta)
      3'd0:    m = HOLD;
      3'd1:    m = UP1;
      3'd7:    m = DN1;
      3'd2:    m = UP2;
      3'd6:    m = DN2;
      default: m = JUMP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stepper_phase_decode.sv
// Combinational drive-vector decoder: maps a coil-drive vector onto its
// phase index; hit is low for any vector outside the phase table.
module stepper_phase_decode
  import stepper_pkg::*;
(
  input  drive_t vec,
  output logic   hit,
  output phase_t idx
);

  // Table lookup; unknown vectors report no hit and index 0.
  always_comb begin
    hit = 1'b1;
    idx = 3'd0;
    case (vec)
      P0:      idx = 3'd0;
      P1:      idx = 3'd1;
      P2:      idx = 3'd2;
      P3:      idx = 3'd3;
      P4:      idx = 3'd4;
      P5:      idx = 3'd5;
      P6:      idx = 3'd6;
      P7:      idx = 3'd7;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/stepper_emulator.sv
// Rotor emulator: registers the coil-drive vector, decodes it into a phase,
// classifies phase transitions and tracks position, angle, strobes, idle
// time and sticky fault flags.
module stepper_emulator
  import stepper_pkg::*;
#(
  parameter int POS_W         = 16,
  parameter int STEPS_PER_REV = 400,
  parameter int ANG_W         = $clog2(STEPS_PER_REV),
  parameter int IDLE_W        = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              D,
  input  logic              INH1,
  input  logic              INH2,
  input  logic              CLR_FAULT,
  output logic [POS_W-1:0]  POSITION,
  output logic [ANG_W-1:0]  ANGLE,
  output logic              STEP,
  output logic              DIR,
  output logic              FULL,
  output logic              REV,
  output logic              BAD_CODE,
  output logic              MISSED,
  output logic [IDLE_W-1:0] IDLE
);

  localparam logic [ANG_W+1:0] REV_N = (ANG_W+2)'(STEPS_PER_REV);

  // Stage 1: input register. in_vld marks that the register holds a real
  // sample, so the all-zero reset content is never decoded as a bad code.
  // CLR_FAULT travels with the vector so a clear and a fault issued
  // together are judged in the same decode cycle.
  drive_t in_q, in_d;
  logic   in_vld_q, in_vld_d;
  logic   clr_q, clr_d;

  // Stage 2 state
  logic              ref_valid_q, ref_valid_d;
  phase_t            ref_phase_q, ref_phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [ANG_W-1:0]  angle_q, angle_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              full_q, full_d;
  logic              rev_q, rev_d;
  logic              bad_q, bad_d;
  logic              missed_q, missed_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic              hit;
  phase_t            idx;
  phase_t            delta;
  move_t             mv_kind;
  logic signed [2:0] mv;
  logic              moving;
  logic              bad_ev;
  logic              miss_ev;
  logic [ANG_W+1:0]  ang_sum;

  stepper_phase_decode u_decode (
    .vec (in_q),
    .hit (hit),
    .idx (idx)
  );

  // Stage-1 next state: capture the raw inputs every cycle.
  always_comb begin
    in_d     = {A, B, C, D, INH1, INH2};
    in_vld_d = 1'b1;
    clr_d    = CLR_FAULT;
  end

  // Stage-2 next state: classify the move and update rotor state.
  always_comb begin
    ref_valid_d = ref_valid_q;
    ref_phase_d = ref_phase_q;
    pos_d       = pos_q;
    angle_d     = angle_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    full_d      = full_q;
    rev_d       = 1'b0;
    idle_d      = idle_q;
    bad_ev      = 1'b0;
    miss_ev     = 1'b0;
    mv_kind     = HOLD;
    mv          = 3'sd0;
    delta       = idx - ref_phase_q;

    if (in_vld_q) begin
      if (!hit) begin
        bad_ev = 1'b1;
      end else if (!ref_valid_q) begin
        ref_valid_d = 1'b1;
        ref_phase_d = idx;
      end else begin
        mv_kind = classify(delta);
        case (mv_kind)
          UP1:  mv = 3'sd1;
          DN1:  mv = 3'b111;
          UP2:  mv = 3'sd2;
          DN2:  mv = 3'b110;
          JUMP: begin
            miss_ev     = 1'b1;
            ref_phase_d = idx;
          end
          default: mv = 3'sd0;
        endcase
      end
    end

    moving  = (mv != 3'sd0);
    ang_sum = {2'b00, angle_q} + {{(ANG_W-1){mv[2]}}, mv};

    if (moving) begin
      ref_phase_d = idx;
      step_d      = 1'b1;
      dir_d       = ~mv[2];
      full_d      = (mv_kind == UP2) || (mv_kind == DN2);
      pos_d       = pos_q + {{(POS_W-3){mv[2]}}, mv};
      idle_d      = '0;
      if (ang_sum[ANG_W+1]) begin
        // Went below zero: wrap to the top of the revolution.
        angle_d = ANG_W'(ang_sum + REV_N);
        rev_d   = 1'b1;
      end else if (ang_sum >= REV_N) begin
        angle_d = ANG_W'(ang_sum - REV_N);
        rev_d   = 1'b1;
      end else begin
        angle_d = ang_sum[ANG_W-1:0];
      end
    end else if (idle_q != '1) begin
      idle_d = idle_q + 1'b1;
    end

    bad_d    = (bad_q & ~clr_q) | bad_ev;
    missed_d = (missed_q & ~clr_q) | miss_ev;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      in_q        <= '0;
      in_vld_q    <= 1'b0;
      clr_q       <= 1'b0;
      ref_valid_q <= 1'b0;
      ref_phase_q <= '0;
      pos_q       <= '0;
      angle_q     <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      full_q      <= 1'b0;
      rev_q       <= 1'b0;
      bad_q       <= 1'b0;
      missed_q    <= 1'b0;
      idle_q      <= '0;
    end else begin
      in_q        <= in_d;
      in_vld_q    <= in_vld_d;
      clr_q       <= clr_d;
      ref_valid_q <= ref_valid_d;
      ref_phase_q <= ref_phase_d;
      pos_q       <= pos_d;
      angle_q     <= angle_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      full_q      <= full_d;
      rev_q       <= rev_d;
      bad_q       <= bad_d;
      missed_q    <= missed_d;
      idle_q      <= idle_d;
    end
  end

  assign POSITION = pos_q;
  assign ANGLE    = angle_q;
  assign STEP     = step_q;
  assign DIR      = dir_q;
  assign FULL     = full_q;
  assign REV      = rev_q;
  assign BAD_CODE = bad_q;
  assign MISSED   = missed_q;
  assign IDLE     = idle_q;

endmodule
